// File: rtl/load_resp_unit_if.sv
// load_resp_unit_if: AXI read-address and read-data channel bundle between the load unit and memory.
interface load_resp_unit_if #(
    parameter int ADDR_W = 32
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;

    modport master (output arvalid, araddr, rready, input arready, rvalid, rdata, rresp);
    modport slave  (input arvalid, araddr, rready, output arready, rvalid, rdata, rresp);
endinterface

// File: rtl/load_resp_unit.sv
// load_resp_unit: MEM-stage load reader; issues one word-aligned AXI read, extends the addressed lane,
// and returns a one-cycle writeback strobe with AdEL / bus-error flags.
module load_resp_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_type,
    input  logic [4:0]        req_rt,
    output logic              req_ready,
    output logic              stall,
    output logic              ld_valid,
    output logic [31:0]       ld_data,
    output logic [4:0]        ld_rt,
    output logic              ld_adel,
    output logic              ld_buserr,
    load_resp_unit_if.master  axi
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t            state, nxt;
    logic [9:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        type_q;
    logic [4:0]        rt_q;
    logic              misal, busy, hs_ar, hs_r, r_ok, tmo, go;
    logic [7:0]        by;
    logic [15:0]       hw;
    logic [31:0]       ext;

    // type[2] set means word access (101..111 alias LW); type[1] alone means halfword
    assign misal = req_type[2] ? |req_addr[1:0] : (req_type[1] & req_addr[0]);
    assign busy  = (state == ADDR) || (state == DATA);
    assign hs_ar = (state == ADDR) && axi.arready;
    assign hs_r  = (state == DATA) && axi.rvalid;
    assign r_ok  = hs_r && (axi.rresp == 2'b00);
    assign tmo   = busy && (cnt == 10'(TIMEOUT_CYCLES - 1));

    assign by  = axi.rdata[{addr_q[1:0], 3'b000} +: 8];
    assign hw  = addr_q[1] ? axi.rdata[31:16] : axi.rdata[15:0];
    assign ext = type_q[2] ? axi.rdata
               : type_q[1] ? {{16{~type_q[0] & hw[15]}}, hw}
               : {{24{~type_q[0] & by[7]}}, by};

    assign req_ready   = (state == IDLE);
    assign stall       = busy || ((state == IDLE) && req_valid && !misal);
    assign ld_valid    = (state == RESP);
    assign axi.arvalid = (state == ADDR);
    assign axi.rready  = (state == DATA);
    assign axi.araddr  = {addr_q[ADDR_W-1:2], 2'b00};

    // a completing handshake takes priority over the timeout in the same cycle
    always_comb begin
        nxt = state;
        if (state == IDLE && req_valid) nxt = misal ? RESP : ADDR;
        else if (hs_ar) nxt = DATA;
        else if (hs_r || tmo) nxt = RESP;
        else if (state == RESP) nxt = IDLE;
    end

    assign go = (nxt == RESP) && (state != RESP);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            type_q    <= '0;
            rt_q      <= '0;
            ld_data   <= '0;
            ld_rt     <= '0;
            ld_adel   <= 1'b0;
            ld_buserr <= 1'b0;
        end else begin
            state     <= nxt;
            cnt       <= busy ? cnt + 10'd1 : '0;
            if (state == IDLE && req_valid) begin
                addr_q <= req_addr;
                type_q <= req_type;
                rt_q   <= req_rt;
            end
            ld_data   <= (go && r_ok) ? ext : '0;
            ld_rt     <= go ? ((state == IDLE) ? req_rt : rt_q) : '0;
            ld_adel   <= go && (state == IDLE);
            ld_buserr <= go && busy && !r_ok;
        end
    end
endmodule

// File: tb/tb_load_resp_unit.sv
// tb_load_resp_unit: directed vectors for load_resp_unit with hand-computed results.
module tb_load_resp_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_type = '0;
    logic [4:0]  req_rt = '0;
    logic        req_ready, stall, ld_valid, ld_adel, ld_buserr;
    logic [31:0] ld_data;
    logic [4:0]  ld_rt;
    int          n_vec = 0;
    int          n_bad = 0;

    load_resp_unit_if #(.ADDR_W(32)) bus ();

    load_resp_unit #(.TIMEOUT_CYCLES(8), .ADDR_W(32)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_type(req_type), .req_rt(req_rt), .req_ready(req_ready), .stall(stall),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_rt(ld_rt), .ld_adel(ld_adel),
        .ld_buserr(ld_buserr), .axi(bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // slave always ready: AR accepted in cycle 1, R returned in cycle 2
    task automatic load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] rs, input logic [4:0] rt, input logic [31:0] ed,
                        input logic ea, input logic eb);
        req_valid = 1'b1; req_addr = a; req_type = t; req_rt = rt;
        bus.arready = 1'b1; bus.rvalid = 1'b1; bus.rdata = d; bus.rresp = rs;
        #1;
        chk("stall_req", stall, {31'b0, !ea});
        step();
        req_valid = 1'b0;
        if (!ea) begin
            chk("arvalid", bus.arvalid, 1);
            chk("araddr", bus.araddr, {a[31:2], 2'b00});
            chk("ld_valid_c1", ld_valid, 0);
            step();
            chk("rready", bus.rready, 1);
            step();
        end else
            chk("arvalid_adel", bus.arvalid, 0);
        chk("ld_valid", ld_valid, 1);
        chk("ld_data", ld_data, ed);
        chk("ld_rt", ld_rt, {27'b0, rt});
        chk("ld_adel", ld_adel, {31'b0, ea});
        chk("ld_buserr", ld_buserr, {31'b0, eb});
        chk("stall_resp", stall, 0);
        step();
        chk("ld_valid_off", ld_valid, 0);
        chk("ld_data_off", ld_data, 0);
        chk("req_ready_back", req_ready, 1);
    endtask

    initial begin
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0;
        #12;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_ld_valid", ld_valid, 0);
        chk("rst_arvalid", bus.arvalid, 0);
        chk("rst_stall", stall, 0);
        reset = 1'b1;
        step();

        load(3'b000, 32'h1000_0003, 32'h8011_2233, 2'b00, 5'd3,  32'hFFFF_FF80, 1'b0, 1'b0);
        load(3'b011, 32'h0000_2002, 32'hBEEF_1234, 2'b00, 5'd4,  32'h0000_BEEF, 1'b0, 1'b0);
        load(3'b010, 32'h0000_2002, 32'hBEEF_1234, 2'b00, 5'd5,  32'hFFFF_BEEF, 1'b0, 1'b0);
        load(3'b001, 32'h0000_2001, 32'hBEEF_1234, 2'b00, 5'd6,  32'h0000_0012, 1'b0, 1'b0);
        load(3'b000, 32'h0000_2000, 32'h1234_5678, 2'b00, 5'd7,  32'h0000_0078, 1'b0, 1'b0);
        load(3'b100, 32'h0000_0100, 32'hCAFE_F00D, 2'b00, 5'd8,  32'hCAFE_F00D, 1'b0, 1'b0);
        load(3'b111, 32'h0000_0104, 32'h0BAD_CAFE, 2'b00, 5'd9,  32'h0BAD_CAFE, 1'b0, 1'b0);
        load(3'b100, 32'h0000_0006, 32'h1111_1111, 2'b00, 5'd10, 32'h0000_0000, 1'b1, 1'b0);
        load(3'b010, 32'h0000_2003, 32'h1111_1111, 2'b00, 5'd11, 32'h0000_0000, 1'b1, 1'b0);
        load(3'b100, 32'h0000_0200, 32'h5555_AAAA, 2'b10, 5'd12, 32'h0000_0000, 1'b0, 1'b1);

        // AR held off 4 cycles with stray R pulses, R arrives exactly on the timeout cycle
        req_valid = 1'b1; req_addr = 32'h0000_3000; req_type = 3'b100; req_rt = 5'd13;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h1234_5678; bus.rresp = 2'b00;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.rvalid = (i == 1 || i == 2);
            bus.rresp  = bus.rvalid ? 2'b10 : 2'b00;
            #1;
            chk("dly_arvalid", bus.arvalid, 1);
            chk("dly_araddr", bus.araddr, 32'h0000_3000);
            chk("dly_stall", stall, 1);
            step();
        end
        bus.arready = 1'b1; bus.rvalid = 1'b0; bus.rresp = 2'b00;
        step();
        bus.arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("dly_rready", bus.rready, 1);
            chk("dly_stall_data", stall, 1);
            chk("dly_no_ld", ld_valid, 0);
            step();
        end
        bus.rvalid = 1'b1;
        step();
        bus.rvalid = 1'b0;
        chk("dly_ld_valid", ld_valid, 1);
        chk("dly_ld_data", ld_data, 32'h1234_5678);
        chk("dly_buserr", ld_buserr, 0);
        step();
        chk("dly_single", ld_valid, 0);

        // AR never accepted: forced bus error after 8 cycles in ADDR
        req_valid = 1'b1; req_addr = 32'h0000_4000; req_type = 3'b100; req_rt = 5'd14;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("tmo_arvalid", bus.arvalid, 1);
            step();
        end
        chk("tmo_ld_valid", ld_valid, 1);
        chk("tmo_buserr", ld_buserr, 1);
        chk("tmo_data", ld_data, 0);
        chk("tmo_arvalid_off", bus.arvalid, 0);
        step();
        chk("tmo_req_ready", req_ready, 1);

        // async reset while waiting in DATA
        req_valid = 1'b1; req_addr = 32'h0000_5000; req_type = 3'b100; req_rt = 5'd15;
        bus.arready = 1'b1; bus.rvalid = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        chk("rst_mid_rready_pre", bus.rready, 1);
        reset = 1'b0;
        #1;
        chk("rst_mid_arvalid", bus.arvalid, 0);
        chk("rst_mid_rready", bus.rready, 0);
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_ld_valid", ld_valid, 0);
        chk("rst_mid_req_ready", req_ready, 1);
        step();
        reset = 1'b1;
        step();
        load(3'b100, 32'h0000_5004, 32'hA5A5_5A5A, 2'b00, 5'd16, 32'hA5A5_5A5A, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/load_resp_unit.md
Name: load_resp_unit

Overview:
Data-side load reader for the MIPS pipeline. It sits between the MEM stage and the AXI read channels. The execute path produces store data and operands toward memory; this block brings load data back. It accepts one load request at a time, issues a word-aligned AR transaction, captures R data, extracts and extends the addressed byte or halfword, and presents a one-cycle writeback result. It stalls the pipeline while the load is in flight and reports misaligned-address (AdEL) and bus errors.

Parameters:
TIMEOUT_CYCLES, 255, cycles allowed in ADDR+DATA before a forced bus error; range 1..1023.
ADDR_W, 32, width of request and AXI address.

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
req_valid  in  1  MEM-stage load request
req_addr  in  ADDR_W  byte address
req_type  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW; 101..111 treated as LW
req_rt  in  5  destination register
req_ready  out  1  high only in IDLE
stall  out  1  pipeline freeze
arvalid  out  1  AXI AR valid
araddr  out  ADDR_W  word-aligned address {req_addr[ADDR_W-1:2],2'b00}
arready  in  1  AXI AR ready
rvalid  in  1  AXI R valid
rdata  in  32  AXI R data
rresp  in  2  AXI R response
rready  out  1  AXI R ready
ld_valid  out  1  one-cycle result strobe
ld_data  out  32  extended load result
ld_rt  out  5  destination register of result
ld_adel  out  1  with ld_valid: misaligned address
ld_buserr  out  1  with ld_valid: rresp!=0 or timeout

Behaviour:
- Reset (reset=0, async): state IDLE, timeout counter 0. All outputs 0 except req_ready=1. Latched addr/type/rt cleared.
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - On req_valid, latch addr, type and rt.
  - Misaligned if type LH/LHU with addr[0]=1, or LW with addr[1:0]!=0. Misaligned -> RESP with adel=1, data=0, and no AR issued.
  - Otherwise -> ADDR, counter cleared.
- ADDR: arvalid=1, araddr stable. arvalid stays high until arready. On arvalid&arready -> DATA.
- DATA: rready=1. On rvalid:
  - rresp!=0 -> RESP with buserr=1, data=0.
  - Otherwise -> RESP with the extracted data.
  - rvalid while not in DATA is ignored, since rready=0.
- Timeout: the counter increments each cycle in ADDR/DATA. When it reaches TIMEOUT_CYCLES-1 with no completing handshake -> RESP with buserr=1, data=0, and arvalid/rready drop. A handshake in the same cycle as the timeout wins.
- RESP: ld_valid=1 for exactly one cycle. ld_data, ld_rt, ld_adel and ld_buserr are registered and stable in that cycle, and cleared to 0 in every other cycle. Then -> IDLE.
- Extraction (little-endian):
  - Byte lane k = addr[1:0] selects rdata[8k+7:8k].
  - Halfword uses addr[1]: 0 selects [15:0], 1 selects [31:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes rdata through.
- stall = 1 in ADDR and DATA, and combinationally in IDLE when req_valid is high and the request is aligned. stall = 0 in RESP.
- Latency: with arready and rvalid both high immediately, req cycle 0 -> ADDR cycle 1 -> DATA cycle 2 -> ld_valid cycle 3. A misaligned request gives ld_valid in cycle 1.
- req_valid is ignored outside IDLE. No back-to-back overlap: one outstanding transaction only.
- Reset asserted mid-transaction aborts immediately to IDLE. The AXI side is also in reset by system convention.

Test Plan:
- LB, addr 0x1000_0003, arready=1, rdata=0x8011_2233 one cycle after arvalid -> ld_valid in cycle 3, ld_data=0xFFFF_FF80, araddr=0x1000_0000, adel=0, buserr=0.
- LHU addr 0x2002, rdata=0xBEEF_1234 -> ld_data=0x0000_BEEF. LH with the same data -> 0xFFFF_BEEF. LBU addr 0x2001 -> 0x0000_0012.
- LW addr 0x0000_0006 -> no arvalid ever, ld_valid in cycle 1 with ld_adel=1, ld_data=0, stall never asserted.
- arready held low 4 cycles, then rvalid delayed 2 cycles with stray rvalid pulses during ADDR -> arvalid/araddr stable, stray pulses ignored, stall high throughout, single ld_valid with the correct data.
- rresp=2'b10 -> ld_buserr=1, ld_data=0. Separately, TIMEOUT_CYCLES=8 with arready never high -> ld_buserr=1 at cycle 9, arvalid deasserted, back to IDLE with req_ready=1.
- reset pulled low in DATA -> same cycle: arvalid=rready=stall=ld_valid=0, req_ready=1. After release, a new LW completes normally.
